midi_msg_parser: RTL and testbench
==================================

Name: midi_msg_parser

Overview:
- Byte-level MIDI message assembler that sits directly downstream of the MIDI UART receiver.
- Consumes one received byte per strobe and tracks running status.
- Emits complete channel-voice and system-common messages as a single-cycle, parallel-field strobe to the MMIO register/FIFO layer.
- Real-time bytes are passed out on a separate strobe without disturbing message assembly.

Parameters:
- NOTE_ON_ZERO_IS_OFF, 1: when 1, Note-On with velocity 0 is reported as Note-Off (status 0x8n), velocity 0.
- SYSEX_ENABLE, 0: when 0, SysEx payload bytes are discarded silently; when 1, they are reported on sx_valid_o/sx_byte_o.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset; asynchronous, active-low
- byte_valid_i  input  1  one-cycle strobe; a received byte is present (driven from the UART rx_done)
- byte_i  input  8  received byte; valid only while byte_valid_i=1
- msg_valid_o  output  1  one-cycle strobe; a complete message is on status_o/data1_o/data2_o
- status_o  output  8  message status byte
- data1_o  output  7  first data byte (0 if none)
- data2_o  output  7  second data byte (0 if none)
- rt_valid_o  output  1  one-cycle strobe; a real-time byte (0xF8-0xFF) was received
- rt_byte_o  output  8  the real-time byte
- sx_valid_o  output  1  SysEx payload byte strobe (SYSEX_ENABLE=1 only; tied 0 otherwise)
- sx_byte_o  output  7  SysEx payload byte
- err_o  output  1  one-cycle strobe; stray data byte discarded

Behaviour:
- Reset (async assert, sync release): state=NoStatus, running status=0, all outputs 0.
- All outputs are registered. Every strobe fires exactly 1 cycle after the byte_valid_i cycle that caused it.
- Field outputs hold their value until the next msg_valid_o.
- Byte classes:
  - data: bit7=0
  - voice status: 0x80-0xEF
  - common: 0xF0-0xF7
  - real-time: 0xF8-0xFF
- Data length: 0xCn, 0xDn, 0xF1, 0xF3 -> 1; 0x8n, 0x9n, 0xAn, 0xBn, 0xEn, 0xF2 -> 2; 0xF6 -> 0.
- States: NoStatus, Need1, Need2, SysEx.
- Real-time byte, in any state: pulse rt_valid_o with rt_byte_o=byte. State, running status and any partial data are untouched.
- Voice status byte, in any state:
  - latch it as running status and clear partial data.
  - go to Need1. For a 1-byte status the message completes on that first data byte.
  - Any partial message is abandoned with no err_o.
- 0xF0: clear running status, go to SysEx.
- 0xF7 outside SysEx: ignore; running status cleared.
- 0xF4/0xF5: ignore; running status cleared; go to NoStatus.
- 0xF6: emit immediately with data1=data2=0; running status cleared; go to NoStatus.
- 0xF1/0xF2/0xF3: latch as current status (not running); go to Need1.
- Data byte in NoStatus: discard and pulse err_o.
- Data byte in Need1:
  - 1-byte message: emit and return to Need1. Running status applies, so the next data byte starts a new message.
  - 2-byte message: store data1, go to Need2.
- Data byte in Need2: emit with data1/data2. Go to Need1 if running status is valid, else NoStatus (system common).
- Completion of a system-common message clears it; the next data byte is stray.
- SysEx state:
  - data bytes -> sx_valid_o if SYSEX_ENABLE, else dropped.
  - 0xF7 -> NoStatus.
  - any other non-real-time status terminates SysEx and is then processed as above, in the same byte.
- NOTE_ON_ZERO_IS_OFF: a Note-On (0x9n) with data2=0 is emitted as status 0x8n. Running status stays 0x9n.
- byte_valid_i is at most once every N cycles (UART rate). No back-pressure; the consumer must accept msg_valid_o every time.
- Reset mid-message drops the partial message; no strobe is produced.

Decomposition:
- Shared package (midi_pkg) holds:
  - midi_parse_state_t enum
  - constants MIDI_SYSEX=0xF0, MIDI_EOX=0xF7, MIDI_TUNE_REQ=0xF6, MIDI_RT_MIN=0xF8
  - function midi_data_len(status) returning 0..2
- No sub-module; a single FSM plus registers (~200 lines).

Test Plan:
- 0x90,0x3C,0x64 -> one msg_valid_o: status 0x90, data1 0x3C, data2 0x64.
- Running status: 0x91,0x40,0x10,0x41,0x00 with NOTE_ON_ZERO_IS_OFF=1 -> two messages:
  - (0x91,0x40,0x10)
  - (0x81,0x41,0x00)
- Real-time interleave: 0xB0,0x07,0xF8,0x7F -> rt_valid_o with rt_byte_o=0xF8 one cycle after the 0xF8 strobe; then one message (0xB0,0x07,0x7F).
- Program change: 0xC5,0x0A,0x0B -> two messages (0xC5,0x0A,0) and (0xC5,0x0B,0).
- SysEx: 0xF0,0x7E,0x01,0xF7,0x22 -> no msg_valid_o; err_o pulses for 0x22. With SYSEX_ENABLE=1, sx_valid_o pulses twice (0x7E, 0x01).
- Reset after 0x90,0x3C; release; send 0x45 -> err_o pulses, no msg_valid_o, all outputs 0 during reset.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI parser states, byte constants and data-length lookup
package midi_pkg;
  typedef enum logic [1:0] {NO_STATUS, NEED1, NEED2, SYSEX} midi_parse_state_t;
  localparam logic [7:0] MIDI_SYSEX = 8'hF0;
  localparam logic [7:0] MIDI_EOX = 8'hF7;
  localparam logic [7:0] MIDI_TUNE_REQ = 8'hF6;
  localparam logic [7:0] MIDI_RT_MIN = 8'hF8;
  function automatic logic [1:0] midi_data_len(input logic [7:0] s);
    return (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3) ? 2'd1 :
           ((s[7] && s[7:4] != 4'hF) || s == 8'hF2) ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: assembles MIDI bytes into complete messages with running status
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit NOTE_ON_ZERO_IS_OFF = 1'b1,
  parameter bit SYSEX_ENABLE = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       msg_valid_o,
  output logic [7:0] status_o,
  output logic [6:0] data1_o,
  output logic [6:0] data2_o,
  output logic       rt_valid_o,
  output logic [7:0] rt_byte_o,
  output logic       sx_valid_o,
  output logic [6:0] sx_byte_o,
  output logic       err_o
);
  midi_parse_state_t state;
  logic [7:0] cur_st;
  logic       run_vld;
  logic [6:0] d1;
  logic [1:0] len;
  logic       is_off;
  assign len = midi_data_len(cur_st);
  assign is_off = NOTE_ON_ZERO_IS_OFF && cur_st[7:4] == 4'h9 && byte_i[6:0] == 7'd0;
  // byte classifier, message FSM and registered output strobes
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= NO_STATUS;
      cur_st <= '0;
      run_vld <= 1'b0;
      d1 <= '0;
      msg_valid_o <= 1'b0;
      status_o <= '0;
      data1_o <= '0;
      data2_o <= '0;
      rt_valid_o <= 1'b0;
      rt_byte_o <= '0;
      sx_valid_o <= 1'b0;
      sx_byte_o <= '0;
      err_o <= 1'b0;
    end else begin
      msg_valid_o <= 1'b0;
      rt_valid_o <= 1'b0;
      sx_valid_o <= 1'b0;
      err_o <= 1'b0;
      if (byte_valid_i) begin
        if (byte_i >= MIDI_RT_MIN) begin
          rt_valid_o <= 1'b1;
          rt_byte_o <= byte_i;
        end else if (byte_i[7] && byte_i < MIDI_SYSEX) begin
          cur_st <= byte_i;
          run_vld <= 1'b1;
          d1 <= '0;
          state <= NEED1;
        end else if (byte_i == MIDI_SYSEX) begin
          run_vld <= 1'b0;
          state <= SYSEX;
        end else if (byte_i == MIDI_TUNE_REQ) begin
          run_vld <= 1'b0;
          state <= NO_STATUS;
          msg_valid_o <= 1'b1;
          status_o <= byte_i;
          data1_o <= '0;
          data2_o <= '0;
        end else if (byte_i[7] && midi_data_len(byte_i) != 2'd0) begin
          cur_st <= byte_i;
          run_vld <= 1'b0;
          d1 <= '0;
          state <= NEED1;
        end else if (byte_i[7]) begin
          run_vld <= 1'b0;
          state <= NO_STATUS;
        end else begin
          case (state)
            NO_STATUS: err_o <= 1'b1;
            NEED1:
              if (len == 2'd1) begin
                msg_valid_o <= 1'b1;
                status_o <= cur_st;
                data1_o <= byte_i[6:0];
                data2_o <= '0;
                state <= run_vld ? NEED1 : NO_STATUS;
              end else begin
                d1 <= byte_i[6:0];
                state <= NEED2;
              end
            NEED2: begin
              msg_valid_o <= 1'b1;
              status_o <= is_off ? {4'h8, cur_st[3:0]} : cur_st;
              data1_o <= d1;
              data2_o <= byte_i[6:0];
              state <= run_vld ? NEED1 : NO_STATUS;
            end
            SYSEX:
              if (SYSEX_ENABLE) begin
                sx_valid_o <= 1'b1;
                sx_byte_o <= byte_i[6:0];
              end
          endcase
        end
      end
    end
endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: directed byte streams checked against hand-computed messages
module tb_midi_msg_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic mv, rv, sv, er, mv2, rv2, sv2, er2;
  logic [7:0] st, rb, st2, rb2;
  logic [6:0] d1, d2, sb, d12, d22, sb2;
  logic c_mv, c_rv, c_er, c_sv2, c_sv;
  logic [7:0] c_st, c_rb;
  logic [6:0] c_d1, c_d2, c_sb2;
  int checks = 0;
  int errors = 0;

  midi_msg_parser u_dut (
    .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .msg_valid_o(mv), .status_o(st), .data1_o(d1), .data2_o(d2),
    .rt_valid_o(rv), .rt_byte_o(rb), .sx_valid_o(sv), .sx_byte_o(sb), .err_o(er)
  );

  midi_msg_parser #(.SYSEX_ENABLE(1'b1)) u_sx (
    .clk_i(clk), .rst_ni(rst_n), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .msg_valid_o(mv2), .status_o(st2), .data1_o(d12), .data2_o(d22),
    .rt_valid_o(rv2), .rt_byte_o(rb2), .sx_valid_o(sv2), .sx_byte_o(sb2), .err_o(er2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in = b;
    @(negedge clk);
    byte_valid = 1'b0;
    {c_mv, c_st, c_d1, c_d2, c_rv, c_rb, c_er, c_sv, c_sv2, c_sb2} =
      {mv, st, d1, d2, rv, rb, er, sv, sv2, sb2};
    @(negedge clk);
    chk("one_shot", {mv, rv, er, sv, sv2}, 5'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_msg(input string tag, input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
    chk(tag, {c_mv, c_st, c_d1, c_d2, c_er}, {1'b1, s, a, b, 1'b0});
  endtask

  task automatic exp_none(input string tag, input logic e);
    chk(tag, {c_mv, c_er, c_rv}, {1'b0, e, 1'b0});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {mv, st, d1, d2, rv, rb, sv, sb, er}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h90); exp_none("non_status", 1'b0);
    send(8'h3C); exp_none("non_d1", 1'b0);
    send(8'h64); exp_msg("note_on", 8'h90, 7'h3C, 7'h64);
    send(8'h91); exp_none("rs_status", 1'b0);
    send(8'h40); exp_none("rs_d1", 1'b0);
    send(8'h10); exp_msg("rs_msg1", 8'h91, 7'h40, 7'h10);
    send(8'h41); exp_none("rs_d1b", 1'b0);
    send(8'h00); exp_msg("rs_vel0_off", 8'h81, 7'h41, 7'h00);
    send(8'h91); send(8'h42); send(8'h05); exp_msg("rs_kept_9n", 8'h91, 7'h42, 7'h05);
    send(8'hB0); send(8'h07);
    send(8'hF8);
    chk("rt_strobe", {c_rv, c_rb, c_mv}, {1'b1, 8'hF8, 1'b0});
    chk("field_hold", {c_st, c_d1, c_d2}, {8'h91, 7'h42, 7'h05});
    send(8'h7F); exp_msg("cc_after_rt", 8'hB0, 7'h07, 7'h7F);
    send(8'hC5);
    send(8'h0A); exp_msg("pc1", 8'hC5, 7'h0A, 7'h00);
    send(8'h0B); exp_msg("pc2", 8'hC5, 7'h0B, 7'h00);
    send(8'hF0); exp_none("sx_start", 1'b0);
    send(8'h7E);
    exp_none("sx_b1", 1'b0);
    chk("sx_b1_en", {c_sv2, c_sb2, c_sv}, {1'b1, 7'h7E, 1'b0});
    send(8'h01);
    chk("sx_b2_en", {c_sv2, c_sb2, c_sv}, {1'b1, 7'h01, 1'b0});
    send(8'hF7); exp_none("sx_eox", 1'b0);
    chk("sx_eox_nosx", c_sv2, 1'b0);
    send(8'h22); exp_none("stray_after_eox", 1'b1);
    send(8'hF6); exp_msg("tune_req", 8'hF6, 7'h00, 7'h00);
    send(8'h11); exp_none("stray_after_f6", 1'b1);
    send(8'hF3); send(8'h05); exp_msg("song_sel", 8'hF3, 7'h05, 7'h00);
    send(8'h06); exp_none("stray_after_common", 1'b1);
    send(8'hF2); send(8'h01); send(8'h02); exp_msg("song_pos", 8'hF2, 7'h01, 7'h02);
    send(8'h03); exp_none("stray_after_f2", 1'b1);
    send(8'hE0); send(8'h10); send(8'hF4); send(8'h20); exp_none("f4_clears_rs", 1'b1);
    send(8'hF0); send(8'h55); send(8'h93); send(8'h30); send(8'h31);
    exp_msg("sx_term_by_voice", 8'h93, 7'h30, 7'h31);
    send(8'h90); send(8'h3C);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {mv, st, d1, d2, rv, rb, sv, sb, er, sb2}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h45); exp_none("post_reset_stray", 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
